// File: rtl/axi4s_video_frame_gate.sv
// ============================================================================
// Module   : axi4s_video_frame_gate
// Summary  : Whole-frame start/stop gate for an AXI4-Stream video link, with
//            optional frame limit and status. Optional line-length checker is
//            enabled by defining AXI4S_VIDEO_FRAME_GATE_LINE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4s_video_frame_gate #(
    parameter int TUSER_WIDTH     = 1,
    parameter int TDATA_WIDTH     = 32,
    parameter int FRAME_NUM_WIDTH = 16,
    parameter int X_NUM           = 640
) (
    input  logic                       aresetn,
    input  logic                       aclk,

    input  logic                       ctl_enable,
    input  logic [FRAME_NUM_WIDTH-1:0] ctl_frame_num,

    output logic                       status_busy,
    output logic [FRAME_NUM_WIDTH-1:0] status_frame_count,
    output logic                       status_done,
    output logic                       status_line_error,

    input  logic [TUSER_WIDTH-1:0]     s_axi4s_tuser,
    input  logic                       s_axi4s_tlast,
    input  logic [TDATA_WIDTH-1:0]     s_axi4s_tdata,
    input  logic                       s_axi4s_tvalid,
    output logic                       s_axi4s_tready,

    output logic [TUSER_WIDTH-1:0]     m_axi4s_tuser,
    output logic                       m_axi4s_tlast,
    output logic [TDATA_WIDTH-1:0]     m_axi4s_tdata,
    output logic                       m_axi4s_tvalid,
    input  logic                       m_axi4s_tready
);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_wait_sof = 2'd1;
    localparam logic [1:0] c_run      = 2'd2;

    localparam logic [FRAME_NUM_WIDTH-1:0] c_count_max = '1;
    localparam logic [FRAME_NUM_WIDTH-1:0] c_count_one = FRAME_NUM_WIDTH'(1);

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic                       r_enable_d;
    logic                       w_enable_rise;
    logic [FRAME_NUM_WIDTH-1:0] r_frame_limit;
    logic [FRAME_NUM_WIDTH-1:0] r_frame_count;
    logic [FRAME_NUM_WIDTH-1:0] w_count_base;
    logic [FRAME_NUM_WIDTH-1:0] w_count_nxt;
    logic                       r_done;
    logic                       w_cke;
    logic                       w_sof;
    logic                       w_limit_hit;
    logic                       w_tready;
    logic                       w_fwd;
    logic                       w_count_inc;
    logic                       w_set_done;

    logic [TUSER_WIDTH-1:0]     r_m_tuser;
    logic                       r_m_tlast;
    logic [TDATA_WIDTH-1:0]     r_m_tdata;
    logic                       r_m_tvalid;

    assign w_cke         = !r_m_tvalid || m_axi4s_tready;
    assign w_sof         = s_axi4s_tuser[0];
    assign w_enable_rise = ctl_enable && !r_enable_d;
    assign w_limit_hit   = (r_frame_limit != '0) && (r_frame_count == r_frame_limit);

    // ------------------------------------------------------------------------
    // Frame gate FSM: next state and per-beat pass/drop decision
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_tready    = 1'b1;
        w_fwd       = 1'b0;
        w_count_inc = 1'b0;
        w_set_done  = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_enable_rise) begin
                    w_state_nxt = c_wait_sof;
                end
            end
            c_wait_sof: begin
                // An SOF is held off only if the slice still owns a stalled beat
                w_tready = w_cke || !w_sof;
                if (!ctl_enable) begin
                    w_state_nxt = c_idle;
                end else if (s_axi4s_tvalid && w_tready && w_sof) begin
                    w_fwd       = 1'b1;
                    w_count_inc = 1'b1;
                    w_state_nxt = c_run;
                end
            end
            c_run: begin
                w_tready = w_cke;
                if (s_axi4s_tvalid && w_cke) begin
                    if (!w_sof) begin
                        w_fwd = 1'b1;
                    end else if (!ctl_enable || w_limit_hit) begin
                        w_state_nxt = c_idle;
                        w_set_done  = w_limit_hit;
                    end else begin
                        w_fwd       = 1'b1;
                        w_count_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    assign w_count_base = w_enable_rise ? '0 : r_frame_count;
    assign w_count_nxt  = (w_count_inc && (w_count_base != c_count_max))
                        ? w_count_base + c_count_one : w_count_base;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= c_idle;
            r_enable_d    <= 1'b0;
            r_frame_limit <= '0;
            r_frame_count <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_enable_d    <= ctl_enable;
            if (w_enable_rise) begin
                r_frame_limit <= ctl_frame_num;
            end
            r_frame_count <= w_count_nxt;
            r_done        <= (r_done && !w_enable_rise) || w_set_done;
        end
    end

    // ------------------------------------------------------------------------
    // Output register slice
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_tvalid <= 1'b0;
            r_m_tuser  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
        end else if (w_cke) begin
            r_m_tvalid <= w_fwd;
            if (w_fwd) begin
                r_m_tuser <= s_axi4s_tuser;
                r_m_tlast <= s_axi4s_tlast;
                r_m_tdata <= s_axi4s_tdata;
            end
        end
    end

`ifdef AXI4S_VIDEO_FRAME_GATE_LINE_CHECK_EN
    localparam int c_cnt_w = $clog2(X_NUM) + 1;
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(X_NUM - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_beat_cnt;
    logic [c_cnt_w-1:0] w_beat_idx;
    logic               w_line_bad;
    logic               r_line_error;

    assign w_beat_idx = w_sof ? '0 : r_beat_cnt;
    assign w_line_bad = w_fwd && (s_axi4s_tlast ? (w_beat_idx != c_last_idx)
                                                : (w_beat_idx == c_last_idx));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_beat_cnt   <= '0;
            r_line_error <= 1'b0;
        end else begin
            if (w_fwd) begin
                r_beat_cnt <= s_axi4s_tlast ? '0 : w_beat_idx + c_cnt_one;
            end
            r_line_error <= (r_line_error && !w_enable_rise) || w_line_bad;
        end
    end

    assign status_line_error = r_line_error;
`else
    // X_NUM only sizes the line checker; a degenerate value is the sole way to raise this
    assign status_line_error = (X_NUM < 1);
`endif

    assign status_busy        = (r_state == c_wait_sof) || (r_state == c_run);
    assign status_frame_count = r_frame_count;
    assign status_done        = r_done;
    assign s_axi4s_tready     = w_tready;
    assign m_axi4s_tvalid     = r_m_tvalid;
    assign m_axi4s_tuser      = r_m_tuser;
    assign m_axi4s_tlast      = r_m_tlast;
    assign m_axi4s_tdata      = r_m_tdata;

endmodule

`default_nettype wire

// File: tb/tb_axi4s_video_frame_gate.sv
// ============================================================================
// Module   : tb_axi4s_video_frame_gate
// Summary  : Directed self-checking bench for axi4s_video_frame_gate using
//            4x2 frames; line checks follow AXI4S_VIDEO_FRAME_GATE_LINE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi4s_video_frame_gate;

    localparam int TUW = 1;
    localparam int TDW = 32;
    localparam int FNW = 16;
    localparam int XN  = 4;
`ifdef AXI4S_VIDEO_FRAME_GATE_LINE_CHECK_EN
    localparam logic c_lc_exp = 1'b1;
`else
    localparam logic c_lc_exp = 1'b0;
`endif

    typedef logic [TUW+TDW:0] beat_t;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic           ctl_enable = 1'b0;
    logic [FNW-1:0] ctl_frame_num = '0;
    logic           status_busy;
    logic [FNW-1:0] status_frame_count;
    logic           status_done;
    logic           status_line_error;
    logic [TUW-1:0] s_axi4s_tuser = '0;
    logic           s_axi4s_tlast = 1'b0;
    logic [TDW-1:0] s_axi4s_tdata = '0;
    logic           s_axi4s_tvalid = 1'b0;
    logic           s_axi4s_tready;
    logic [TUW-1:0] m_axi4s_tuser;
    logic           m_axi4s_tlast;
    logic [TDW-1:0] m_axi4s_tdata;
    logic           m_axi4s_tvalid;
    logic           m_axi4s_tready = 1'b1;

    int    n_checks = 0;
    int    n_errors = 0;
    logic  rand_ready = 1'b0;
    beat_t exp_q[$];
    beat_t cap_q[$];
    logic  r_hold = 1'b0;
    beat_t r_hold_beat = '0;
    int    st;

    always #5 aclk = ~aclk;

    axi4s_video_frame_gate #(
        .TUSER_WIDTH    (TUW),
        .TDATA_WIDTH    (TDW),
        .FRAME_NUM_WIDTH(FNW),
        .X_NUM          (XN)
    ) u_dut (
        .aresetn           (aresetn),
        .aclk              (aclk),
        .ctl_enable        (ctl_enable),
        .ctl_frame_num     (ctl_frame_num),
        .status_busy       (status_busy),
        .status_frame_count(status_frame_count),
        .status_done       (status_done),
        .status_line_error (status_line_error),
        .s_axi4s_tuser     (s_axi4s_tuser),
        .s_axi4s_tlast     (s_axi4s_tlast),
        .s_axi4s_tdata     (s_axi4s_tdata),
        .s_axi4s_tvalid    (s_axi4s_tvalid),
        .s_axi4s_tready    (s_axi4s_tready),
        .m_axi4s_tuser     (m_axi4s_tuser),
        .m_axi4s_tlast     (m_axi4s_tlast),
        .m_axi4s_tdata     (m_axi4s_tdata),
        .m_axi4s_tvalid    (m_axi4s_tvalid),
        .m_axi4s_tready    (m_axi4s_tready)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: records transfers and checks a stalled beat stays put
    always @(negedge aclk) begin
        #2;
        if (!aresetn) begin
            r_hold <= 1'b0;
        end else begin
            if (r_hold) begin
                check_val("hold_valid", 64'(m_axi4s_tvalid), 64'(1));
                check_val("hold_beat", 64'({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}),
                          64'(r_hold_beat));
            end
            if (m_axi4s_tvalid && m_axi4s_tready)
                cap_q.push_back({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata});
            r_hold      <= m_axi4s_tvalid && !m_axi4s_tready;
            r_hold_beat <= {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata};
        end
    end

    task automatic send_beat(input logic sof, input logic last, input logic [TDW-1:0] data,
                             input int ctl_act, output int waits);
        logic acc;
        acc   = 1'b0;
        waits = 0;
        @(negedge aclk);
        s_axi4s_tvalid = 1'b1;
        s_axi4s_tuser  = sof;
        s_axi4s_tlast  = last;
        s_axi4s_tdata  = data;
        if (ctl_act >= 0) ctl_enable = ctl_act[0];
        while (!acc) begin
            if (rand_ready) m_axi4s_tready = 1'($urandom_range(0, 1));
            #1 acc = s_axi4s_tready;
            @(posedge aclk);
            if (!acc) begin
                waits++;
                if (waits > 200) begin
                    check_val("accept_timeout", 64'(0), 64'(1));
                    break;
                end
                @(negedge aclk);
            end
        end
    endtask

    // Frame f: line 0 has l0 beats, line 1 has 4; sends beats b0..b1 (b1 < 0 = to end)
    task automatic send_frame(input int f, input int l0, input int b0, input int b1,
                              input int ctl_beat, input int ctl_val, output int stalls);
        int n, w, last_b;
        n      = l0 + 4;
        last_b = (b1 < 0) ? n - 1 : b1;
        stalls = 0;
        for (int b = b0; b <= last_b; b++) begin
            send_beat(b == 0, (b == l0 - 1) || (b == n - 1), {16'(f), 16'(b)},
                      (b == ctl_beat) ? ctl_val : -1, w);
            if (b > 0) stalls += w;
        end
        #1;
    endtask

    task automatic push_frame(input int f, input int l0);
        int n;
        n = l0 + 4;
        for (int b = 0; b < n; b++)
            exp_q.push_back({1'(b == 0), 1'((b == l0 - 1) || (b == n - 1)), 16'(f), 16'(b)});
    endtask

    task automatic idle(input int n);
        @(negedge aclk);
        s_axi4s_tvalid = 1'b0;
        repeat (n - 1) @(negedge aclk);
        #1;
    endtask

    task automatic compare_capture(input string tag);
        int n;
        #3;
        check_val({tag, "_beats"}, 64'(cap_q.size()), 64'(exp_q.size()));
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_val($sformatf("%s[%0d]", tag, i), 64'(cap_q[i]), 64'(exp_q[i]));
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag, input logic busy, input int cnt, input logic done);
        check_val({tag, "_busy"}, 64'(status_busy), 64'(busy));
        check_val({tag, "_count"}, 64'(status_frame_count), 64'(cnt));
        check_val({tag, "_done"}, 64'(status_done), 64'(done));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge aclk);
        check_val("rst_m_tvalid", 64'(m_axi4s_tvalid), 64'(0));
        check_val("rst_s_tready", 64'(s_axi4s_tready), 64'(1));
        check_val("rst_line_err", 64'(status_line_error), 64'(0));
        check_status("rst", 1'b0, 0, 1'b0);
        aresetn = 1'b1;
        idle(2);

        // Continuous mode, enable raised at beat 3 of frame 0, dropped at beat 3 of frame 4
        send_frame(0, 4, 0, -1, 3, 1, st);
        check_status("wait_sof", 1'b1, 0, 1'b0);
        send_frame(1, 4, 0, -1, -1, 0, st);
        check_status("cont_f1", 1'b1, 1, 1'b0);
        send_frame(2, 4, 0, -1, -1, 0, st);
        check_status("cont_f2", 1'b1, 2, 1'b0);
        send_frame(3, 4, 0, -1, -1, 0, st);
        check_status("cont_f3", 1'b1, 3, 1'b0);
        send_frame(4, 4, 0, -1, 3, 0, st);
        check_status("drop_mid", 1'b1, 4, 1'b0);
        send_frame(5, 4, 0, -1, -1, 0, st);
        check_status("stop_sof", 1'b0, 4, 1'b0);
        check_val("idle_stalls", 64'(st), 64'(0));
        check_val("line_err_ok", 64'(status_line_error), 64'(0));
        push_frame(1, 4); push_frame(2, 4); push_frame(3, 4); push_frame(4, 4);
        idle(5);
        compare_capture("cont");

        // Two-frame limit, enable held high
        @(negedge aclk);
        ctl_frame_num = 16'd2;
        ctl_enable    = 1'b1;
        idle(2);
        check_status("lim_start", 1'b1, 0, 1'b0);
        send_frame(10, 4, 0, -1, -1, 0, st);
        send_frame(11, 4, 0, -1, -1, 0, st);
        check_status("lim_f11", 1'b1, 2, 1'b0);
        send_frame(12, 4, 0, -1, -1, 0, st);
        check_status("lim_done", 1'b0, 2, 1'b1);
        send_frame(13, 4, 0, -1, -1, 0, st);
        check_status("lim_norestart", 1'b0, 2, 1'b1);
        push_frame(10, 4); push_frame(11, 4);
        idle(5);
        compare_capture("limit");

        // Random downstream backpressure, continuous
        @(negedge aclk);
        ctl_enable = 1'b0;
        idle(2);
        ctl_frame_num = 16'd0;
        ctl_enable    = 1'b1;
        idle(2);
        check_status("bp_start", 1'b1, 0, 1'b0);
        rand_ready = 1'b1;
        send_frame(20, 4, 0, -1, -1, 0, st);
        send_frame(21, 4, 0, -1, -1, 0, st);
        send_frame(22, 4, 0, -1, 5, 0, st);
        send_frame(23, 4, 0, -1, -1, 0, st);
        check_val("bp_idle_stalls", 64'(st), 64'(0));
        rand_ready     = 1'b0;
        m_axi4s_tready = 1'b1;
        check_status("bp_end", 1'b0, 3, 1'b0);
        push_frame(20, 4); push_frame(21, 4); push_frame(22, 4);
        idle(5);
        compare_capture("bp");

        // Short first line (tlast on beat 2)
        @(negedge aclk);
        ctl_enable = 1'b1;
        idle(2);
        send_frame(40, 3, 0, -1, -1, 0, st);
        check_val("line_err_set", 64'(status_line_error), 64'(c_lc_exp));
        send_frame(41, 4, 0, -1, -1, 0, st);
        check_val("line_err_sticky", 64'(status_line_error), 64'(c_lc_exp));
        push_frame(40, 3); push_frame(41, 4);
        idle(5);
        compare_capture("line");
        @(negedge aclk);
        ctl_enable = 1'b0;
        idle(2);
        ctl_enable = 1'b1;
        idle(2);
        check_val("line_err_clr", 64'(status_line_error), 64'(0));

        // Asynchronous reset while the slice holds a stalled beat mid-frame
        send_frame(30, 4, 0, -1, -1, 0, st);
        send_frame(31, 4, 0, 2, -1, 0, st);
        m_axi4s_tready = 1'b0;
        s_axi4s_tvalid = 1'b0;
        #1;
        check_val("pre_rst_tvalid", 64'(m_axi4s_tvalid), 64'(1));
        #1;
        aresetn = 1'b0;
        #1;
        check_val("arst_tvalid", 64'(m_axi4s_tvalid), 64'(0));
        check_val("arst_tdata", 64'(m_axi4s_tdata), 64'(0));
        check_val("arst_line_err", 64'(status_line_error), 64'(0));
        check_status("arst", 1'b0, 0, 1'b0);
        ctl_enable     = 1'b0;
        m_axi4s_tready = 1'b1;
        repeat (2) @(negedge aclk);
        cap_q.delete();
        exp_q.delete();
        aresetn = 1'b1;
        send_frame(31, 4, 3, -1, -1, 0, st);
        send_frame(32, 4, 0, -1, -1, 0, st);
        send_frame(33, 4, 0, -1, 2, 1, st);
        check_status("post_rst_wait", 1'b1, 0, 1'b0);
        send_frame(34, 4, 0, -1, -1, 0, st);
        check_status("post_rst_run", 1'b1, 1, 1'b0);
        push_frame(34, 4);
        idle(5);
        compare_capture("post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
